// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver with 16x-style oversampling, mid-bit sampling,
// one-entry valid/ready output register, framing-error pulse and sticky overrun.
module uart_rx_cmd #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TCW = $clog2(OVERSAMPLE);

  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_cmd: CLK_FREQ must be at least BAUD*OVERSAMPLE");
  end

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
    $error("uart_rx_cmd: OVERSAMPLE must be even and at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t         state;
  logic           rx_m;
  logic           rx_s;
  logic [DCW-1:0] div_cnt;
  logic [TCW-1:0] tick_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           tick;
  logic           sample;
  logic           start_edge;
  logic           good_stop;
  logic           handshake;

  assign start_edge = (state == S_IDLE) && !rx_s;
  assign tick       = (div_cnt == DIV_LAST);
  assign good_stop  = (state == S_STOP) && sample && rx_s;
  assign handshake  = valid && ready;
  assign busy       = (state != S_IDLE);

  // Start bit is checked at half a bit period; every later sample is a full bit apart.
  always_comb begin
    sample = 1'b0;
    if (tick) begin
      if (state == S_START) sample = (tick_cnt == HALF_LAST);
      else                  sample = (tick_cnt == FULL_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (start_edge || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (sample) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (sample) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state   <= S_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (sample) begin
            tick_cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A good stop coinciding with a handshake replaces the byte and counts as a consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (good_stop) begin
      if (!valid || ready) begin
        data  <= shift;
        valid <= 1'b1;
        if (valid) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (handshake) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
